// File: rtl/pin_entry_fsm.sv
// Assembles a NUM_DIGITS-digit BCD PIN from debounced INC/DEC/NEXT/CLR button pulses.
// Latency: digit/pos update 1 cycle after a pulse; pin_valid strobes 1 cycle after the final NEXT.
// No backpressure: pulses are accepted every cycle, and pulses in DONE are dropped.
module pin_entry_fsm #(
  parameter int NUM_DIGITS     = 4,
  parameter int TIMEOUT_CYCLES = 1000000000,
  parameter int CNT_W          = 30,
  localparam int POS_W         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    btn_inc,
  input  logic                    btn_dec,
  input  logic                    btn_next,
  input  logic                    btn_clr,
  output logic                    entry_active,
  output logic [3:0]              digit_cur,
  output logic [POS_W-1:0]        pos_cur,
  output logic [4*NUM_DIGITS-1:0] pin_value,
  output logic                    pin_valid,
  output logic                    timeout
);

  localparam logic [POS_W-1:0] LAST_POS = POS_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTRY = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [4*NUM_DIGITS-1:0] store_q, store_d;
  logic [4*NUM_DIGITS-1:0] pin_q, pin_d;
  logic [POS_W-1:0]        pos_q, pos_d;
  logic [3:0]              digit_q, digit_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  // Any pulse, including a self-cancelling inc+dec, counts as user activity.
  logic any_btn;
  logic expire;

  assign any_btn = btn_inc | btn_dec | btn_next | btn_clr;
  // A pulse arriving in the expiry cycle wins over the timeout.
  assign expire  = (state_q == ENTRY) && (cnt_q == CNT_LAST) && !any_btn;

  // State register and datapath registers; async reset returns everything to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      store_q <= '0;
      pin_q   <= '0;
      pos_q   <= '0;
      digit_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      store_q <= store_d;
      pin_q   <= pin_d;
      pos_q   <= pos_d;
      digit_q <= digit_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and datapath update: priority is clr > next > inc/dec > timeout.
  always_comb begin
    state_d = state_q;
    store_d = store_q;
    pos_d   = pos_q;
    digit_d = digit_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE: begin
        // The waking pulse is consumed: it only opens a fresh entry.
        cnt_d = '0;
        if (any_btn) begin
          state_d = ENTRY;
          store_d = '0;
          pos_d   = '0;
          digit_d = '0;
        end
      end

      ENTRY: begin
        cnt_d = any_btn ? '0 : cnt_q + CNT_W'(1);
        if (btn_clr) begin
          store_d = '0;
          pos_d   = '0;
          digit_d = '0;
        end else if (btn_next) begin
          // Digit 0 lives in the most significant nibble.
          for (int i = 0; i < NUM_DIGITS; i++) begin
            if (pos_q == POS_W'(i)) begin
              store_d[4*(NUM_DIGITS-1-i) +: 4] = digit_q;
            end
          end
          digit_d = '0;
          if (pos_q == LAST_POS) begin
            state_d = DONE;
            pos_d   = '0;
          end else begin
            pos_d = pos_q + POS_W'(1);
          end
        end else if (btn_inc && !btn_dec) begin
          digit_d = (digit_q >= 4'd9) ? 4'd0 : digit_q + 4'd1;
        end else if (btn_dec && !btn_inc) begin
          digit_d = (digit_q == 4'd0 || digit_q > 4'd9) ? 4'd9 : digit_q - 4'd1;
        end else if (expire) begin
          state_d = IDLE;
          store_d = '0;
          pos_d   = '0;
          digit_d = '0;
          cnt_d   = '0;
        end
      end

      DONE: begin
        // Single presentation cycle; pulses here are ignored.
        state_d = IDLE;
        store_d = '0;
        pos_d   = '0;
        digit_d = '0;
        cnt_d   = '0;
      end

      default: begin
        state_d = IDLE;
        store_d = '0;
        pos_d   = '0;
        digit_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // The reported PIN only changes on the transition into DONE, so partial entries never leak.
  always_comb begin
    pin_d = pin_q;
    if (state_q == ENTRY && state_d == DONE) begin
      pin_d = store_d;
    end
  end

  // Output decode: display fields read zero outside ENTRY.
  always_comb begin
    entry_active = (state_q == ENTRY);
    digit_cur    = (state_q == ENTRY) ? digit_q : 4'd0;
    pos_cur      = (state_q == ENTRY) ? pos_q : '0;
    pin_valid    = (state_q == DONE);
    timeout      = expire;
  end

  assign pin_value = pin_q;

endmodule

// File: tb/tb_pin_entry_fsm.sv
// Directed testbench for pin_entry_fsm with a 100-cycle timeout.
// Outputs are sampled 1 time unit after each rising edge.
// Button pulses are driven for exactly one cycle each.
module tb_pin_entry_fsm;

  logic        clk;
  logic        rst_n;
  logic        btn_inc, btn_dec, btn_next, btn_clr;
  logic        entry_active;
  logic [3:0]  digit_cur;
  logic [1:0]  pos_cur;
  logic [15:0] pin_value;
  logic        pin_valid;
  logic        timeout;

  int tests_run = 0;
  int tests_failed = 0;

  pin_entry_fsm #(
    .NUM_DIGITS(4),
    .TIMEOUT_CYCLES(100),
    .CNT_W(7)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_inc(btn_inc),
    .btn_dec(btn_dec),
    .btn_next(btn_next),
    .btn_clr(btn_clr),
    .entry_active(entry_active),
    .digit_cur(digit_cur),
    .pos_cur(pos_cur),
    .pin_value(pin_value),
    .pin_valid(pin_valid),
    .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic press(input logic i, input logic d, input logic n, input logic c);
    btn_inc = i; btn_dec = d; btn_next = n; btn_clr = c;
    @(posedge clk); #1;
    btn_inc = 1'b0; btn_dec = 1'b0; btn_next = 1'b0; btn_clr = 1'b0;
  endtask

  task automatic press_n(input logic i, input logic d, input int cnt);
    repeat (cnt) press(i, d, 1'b0, 1'b0);
  endtask

  task automatic idle(input int cnt);
    repeat (cnt) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    btn_inc = 1'b0; btn_dec = 1'b0; btn_next = 1'b0; btn_clr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++; if (entry_active !== 1'b0) begin tests_failed++; $display("FAIL reset_active: got %b exp 0", entry_active); end
    tests_run++; if (digit_cur !== 4'd0) begin tests_failed++; $display("FAIL reset_digit: got %0d exp 0", digit_cur); end
    tests_run++; if (pos_cur !== 2'd0) begin tests_failed++; $display("FAIL reset_pos: got %0d exp 0", pos_cur); end
    tests_run++; if (pin_value !== 16'h0000) begin tests_failed++; $display("FAIL reset_pin: got %h exp 0000", pin_value); end
    tests_run++; if ({pin_valid, timeout} !== 2'b00) begin tests_failed++; $display("FAIL reset_strobes: got %b exp 00", {pin_valid, timeout}); end
  endtask

  task automatic test_full_pin();
    press(1, 0, 0, 0); // wake, not applied
    tests_run++; if (entry_active !== 1'b1 || digit_cur !== 4'd0) begin tests_failed++; $display("FAIL wake: active %b digit %0d exp 1/0", entry_active, digit_cur); end
    press_n(1, 0, 3);
    tests_run++; if (digit_cur !== 4'd3) begin tests_failed++; $display("FAIL full_inc3: got %0d exp 3", digit_cur); end
    press(0, 0, 1, 0);
    tests_run++; if (pos_cur !== 2'd1 || digit_cur !== 4'd0) begin tests_failed++; $display("FAIL full_next1: pos %0d digit %0d exp 1/0", pos_cur, digit_cur); end
    press_n(1, 0, 7);
    press(0, 0, 1, 0);
    press(0, 1, 0, 0);
    tests_run++; if (digit_cur !== 4'd9) begin tests_failed++; $display("FAIL full_dec: got %0d exp 9", digit_cur); end
    press(0, 0, 1, 0);
    tests_run++; if (pin_valid !== 1'b0) begin tests_failed++; $display("FAIL full_early_valid: got %b exp 0", pin_valid); end
    press(0, 0, 1, 0);
    tests_run++; if (pin_valid !== 1'b1 || pin_value !== 16'h3790) begin tests_failed++; $display("FAIL full_done: valid %b pin %h exp 1/3790", pin_valid, pin_value); end
    idle(1);
    tests_run++; if (pin_valid !== 1'b0 || entry_active !== 1'b0) begin tests_failed++; $display("FAIL full_after: valid %b active %b exp 0/0", pin_valid, entry_active); end
    tests_run++; if (pin_value !== 16'h3790) begin tests_failed++; $display("FAIL full_hold: got %h exp 3790", pin_value); end
  endtask

  task automatic test_wrap();
    do_reset();
    press(0, 1, 0, 0); // wake
    press(0, 1, 0, 0);
    tests_run++; if (digit_cur !== 4'd9) begin tests_failed++; $display("FAIL wrap_dec: got %0d exp 9", digit_cur); end
    press(1, 0, 0, 0);
    tests_run++; if (digit_cur !== 4'd0) begin tests_failed++; $display("FAIL wrap_inc: got %0d exp 0", digit_cur); end
    press_n(1, 0, 10);
    tests_run++; if (digit_cur !== 4'd0) begin tests_failed++; $display("FAIL wrap_inc10: got %0d exp 0", digit_cur); end
  endtask

  task automatic test_clear();
    press(0, 0, 0, 1); // start clean from the ongoing entry
    press_n(1, 0, 5);
    press(0, 0, 1, 0);
    press_n(1, 0, 2);
    tests_run++; if (pos_cur !== 2'd1 || digit_cur !== 4'd2) begin tests_failed++; $display("FAIL clr_pre: pos %0d digit %0d exp 1/2", pos_cur, digit_cur); end
    press(0, 0, 0, 1);
    tests_run++; if (pos_cur !== 2'd0 || digit_cur !== 4'd0 || entry_active !== 1'b1) begin tests_failed++; $display("FAIL clr: pos %0d digit %0d active %b exp 0/0/1", pos_cur, digit_cur, entry_active); end
    for (int k = 0; k < 4; k++) begin
      press(1, 0, 0, 0);
      press(0, 0, 1, 0);
    end
    tests_run++; if (pin_valid !== 1'b1 || pin_value !== 16'h1111) begin tests_failed++; $display("FAIL clr_pin: valid %b pin %h exp 1/1111", pin_valid, pin_value); end
    idle(1);
  endtask

  task automatic test_timeout();
    int first_to;
    int to_cnt;
    int pv_cnt;
    first_to = 0; to_cnt = 0; pv_cnt = 0;
    press(1, 0, 0, 0); // wake
    press(1, 0, 0, 0); // sample 1 here: counter at 0
    for (int i = 1; i <= 110; i++) begin
      if (timeout === 1'b1) begin
        to_cnt++;
        if (first_to == 0) first_to = i;
      end
      if (pin_valid === 1'b1) pv_cnt++;
      idle(1);
    end
    tests_run++; if (first_to != 100) begin tests_failed++; $display("FAIL to_when: got %0d exp 100", first_to); end
    tests_run++; if (to_cnt != 1) begin tests_failed++; $display("FAIL to_count: got %0d exp 1", to_cnt); end
    tests_run++; if (pv_cnt != 0) begin tests_failed++; $display("FAIL to_valid: got %0d exp 0", pv_cnt); end
    tests_run++; if (entry_active !== 1'b0 || pin_value !== 16'h1111) begin tests_failed++; $display("FAIL to_after: active %b pin %h exp 0/1111", entry_active, pin_value); end

    // Pulse in the expiry cycle wins and restarts the count.
    to_cnt = 0;
    press(1, 0, 0, 0); // wake
    press(1, 0, 0, 0); // counter 0, digit 1
    for (int i = 0; i < 99; i++) begin
      if (timeout === 1'b1) to_cnt++;
      idle(1);
    end
    press(1, 0, 0, 0); // lands in the expiry cycle
    tests_run++; if (to_cnt != 0 || entry_active !== 1'b1 || digit_cur !== 4'd2) begin tests_failed++; $display("FAIL to_pulse_wins: to %0d active %b digit %0d exp 0/1/2", to_cnt, entry_active, digit_cur); end
    for (int i = 0; i < 99; i++) begin
      if (timeout === 1'b1) to_cnt++;
      idle(1);
    end
    tests_run++; if (to_cnt != 0 || timeout !== 1'b1) begin tests_failed++; $display("FAIL to_reload: early %0d now %b exp 0/1", to_cnt, timeout); end
    idle(1);
  endtask

  task automatic test_simultaneous();
    press(1, 0, 0, 0); // wake
    press_n(1, 0, 4);
    press(1, 1, 0, 0);
    tests_run++; if (digit_cur !== 4'd4 || entry_active !== 1'b1) begin tests_failed++; $display("FAIL sim_incdec: digit %0d active %b exp 4/1", digit_cur, entry_active); end
    press(1, 0, 1, 0);
    tests_run++; if (pos_cur !== 2'd1 || digit_cur !== 4'd0) begin tests_failed++; $display("FAIL sim_nextinc: pos %0d digit %0d exp 1/0", pos_cur, digit_cur); end
    press_n(1, 0, 2);
    press(0, 0, 1, 1);
    tests_run++; if (pos_cur !== 2'd0 || digit_cur !== 4'd0) begin tests_failed++; $display("FAIL sim_clrnext: pos %0d digit %0d exp 0/0", pos_cur, digit_cur); end
    press_n(1, 0, 4);
    press(1, 0, 1, 0);
    press(0, 0, 1, 0);
    press(0, 0, 1, 0);
    press(0, 0, 1, 0);
    tests_run++; if (pin_valid !== 1'b1 || pin_value !== 16'h4000) begin tests_failed++; $display("FAIL sim_pin: valid %b pin %h exp 1/4000", pin_valid, pin_value); end
    idle(1);
  endtask

  task automatic test_async_reset();
    int pv_cnt;
    pv_cnt = 0;
    press(1, 0, 0, 0); // wake
    press(1, 0, 0, 0); press(0, 0, 1, 0);
    press(1, 0, 0, 0); press(0, 0, 1, 0);
    press(1, 0, 0, 0);
    tests_run++; if (pos_cur !== 2'd2 || digit_cur !== 4'd1) begin tests_failed++; $display("FAIL ar_pre: pos %0d digit %0d exp 2/1", pos_cur, digit_cur); end
    #2 rst_n = 1'b0;
    #1;
    tests_run++; if ({entry_active, digit_cur, pos_cur, pin_value, pin_valid, timeout} !== 25'd0) begin tests_failed++; $display("FAIL ar_now: act %b d %0d p %0d pin %h v %b t %b exp all 0", entry_active, digit_cur, pos_cur, pin_value, pin_valid, timeout); end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (pin_valid === 1'b1) pv_cnt++;
    end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (pin_valid === 1'b1) pv_cnt++;
    end
    tests_run++; if (pv_cnt != 0 || entry_active !== 1'b0 || pin_value !== 16'h0000) begin tests_failed++; $display("FAIL ar_after: valid %0d active %b pin %h exp 0/0/0000", pv_cnt, entry_active, pin_value); end
  endtask

  initial begin
    rst_n = 1'b0;
    btn_inc = 1'b0; btn_dec = 1'b0; btn_next = 1'b0; btn_clr = 1'b0;
    test_reset();
    test_full_pin();
    test_wrap();
    test_clear();
    test_timeout();
    test_simultaneous();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
